// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - Iterative MIPS multiply/divide unit owning HI/LO
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   ex_valid_i        EX slot holds a real instruction
//   funct_i, rtype_i  funct field and R-type flag from ID/EX
//   rs_data_i         dividend / multiplicand / mthi-mtlo source
//   rt_data_i         divisor / multiplier
//   hilo_rdata_o      HI for mfhi, LO for mflo, else 0 (combinational)
//   hi_o, lo_o        architectural HI/LO registers
//   busy_o            iterative operation in flight
//   stall_o           hold the front of the pipe (HI/LO user while busy)
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid_i,
    input  logic [5:0]       funct_i,
    input  logic             rtype_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    output logic [WIDTH-1:0] hilo_rdata_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             stall_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] prod_q;     // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   opnd_q;     // multiplicand (mult) or divisor (div) magnitude
    logic [WIDTH-1:0]   quo_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH:0]     rem_q;      // partial remainder, one guard bit
    logic [CW-1:0]      count_q;
    logic               sign_q, sign_r, op_div, div_zero;

    // Decode
    logic dec, is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic is_mul_any, is_div_any, hilo_use, accept;

    assign dec        = ex_valid_i & rtype_i;
    assign is_mult    = dec & (funct_i == F_MULT);
    assign is_multu   = dec & (funct_i == F_MULTU);
    assign is_div     = dec & (funct_i == F_DIV);
    assign is_divu    = dec & (funct_i == F_DIVU);
    assign is_mfhi    = dec & (funct_i == F_MFHI);
    assign is_mthi    = dec & (funct_i == F_MTHI);
    assign is_mflo    = dec & (funct_i == F_MFLO);
    assign is_mtlo    = dec & (funct_i == F_MTLO);
    assign is_mul_any = is_mult | is_multu;
    assign is_div_any = is_div | is_divu;
    assign hilo_use   = is_mul_any | is_div_any | is_mfhi | is_mthi | is_mflo | is_mtlo;

    assign busy_o  = (state != IDLE);
    assign stall_o = busy_o & hilo_use;
    assign accept  = (state == IDLE) & (is_mul_any | is_div_any);

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign hilo_rdata_o = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

    // Operand magnitudes; sign bits only count for the signed opcodes
    logic             signed_op, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign signed_op = is_mult | is_div;
    assign sa        = signed_op & rs_data_i[WIDTH-1];
    assign sb        = signed_op & rt_data_i[WIDTH-1];
    assign mag_a     = sa ? (~rs_data_i + 1'b1) : rs_data_i;
    assign mag_b     = sb ? (~rt_data_i + 1'b1) : rt_data_i;

    // One shift-add multiply step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;

    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

    // One restoring divide step; diff[WIDTH] set means the trial subtract went negative
    logic [WIDTH:0] div_shift, div_diff;

    assign div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    // Sign fix-up. Division by zero leaves |rs| in the remainder, and restoring
    // its sign reproduces rs exactly, so only the quotient needs overriding.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = sign_q ? (~prod_q + 1'b1) : prod_q;
    assign quo_fix  = div_zero ? '1 : (sign_q ? (~quo_q + 1'b1) : quo_q);
    assign rem_fix  = sign_r ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    logic last_iter;
    assign last_iter = (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_mul_any) begin
                    state_nxt = MUL;
                end else if (is_div_any) begin
                    state_nxt = DIV;
                end
            end
            MUL:     if (last_iter) state_nxt = FIX;
            DIV:     if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            op_div   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prod_q   <= {{WIDTH{1'b0}}, mag_b};
                        opnd_q   <= is_div_any ? mag_b : mag_a;
                        quo_q    <= mag_a;
                        rem_q    <= '0;
                        count_q  <= '0;
                        sign_q   <= sa ^ sb;
                        sign_r   <= sa;
                        op_div   <= is_div_any;
                        div_zero <= (rt_data_i == '0);
                    end
                    if (is_mthi) hi_q <= rs_data_i;
                    if (is_mtlo) lo_q <= rs_data_i;
                end
                MUL: begin
                    prod_q  <= prod_step;
                    count_q <= count_q + 1'b1;
                end
                DIV: begin
                    if (div_diff[WIDTH]) begin
                        rem_q <= div_shift;
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q <= div_diff;
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end
                    count_q <= count_q + 1'b1;
                end
                FIX: begin
                    if (op_div) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
